// File: rtl/nexys_starship_spawner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : nexys_starship_spawner
// Brief   : LFSR-driven per-lane monster spawn scheduler with difficulty ramp.
// Revision: 1.0
//------------------------------------------------------------------------------
module nexys_starship_spawner #(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [7:0]  INIT_INTERVAL = 8'd40,
  parameter logic [7:0]  MIN_INTERVAL  = 8'd8,
  parameter logic [7:0]  INTERVAL_STEP = 8'd2,
  parameter logic [7:0]  RAMP_PERIOD   = 8'd50
) (
  input  logic       timerClk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic [3:0] lane_full,
  output logic [3:0] spawn,
  output logic [7:0] interval,
  output logic [3:0] level,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Done
);

  localparam logic [2:0]  S_IDLE     = 3'b001;
  localparam logic [2:0]  S_RUN      = 3'b010;
  localparam logic [2:0]  S_DONE     = 3'b100;
  localparam logic [15:0] c_LFSR_TAP = 16'hB400;

  logic [2:0]  r_state;
  logic [7:0]  r_countdown;
  logic [7:0]  r_ramp_cnt;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [3:0]  w_pick;
  logic [1:0]  w_lane;
  logic        w_ramp;
  logic [7:0]  w_interval_ramped;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; the all-zero lockup reloads the seed.
  assign w_lfsr_next = (r_lfsr == 16'h0000) ? LFSR_SEED :
                       ({1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAP : 16'h0000));

  // Scan from the highest offset down so the lowest free offset from the base lane wins.
  always_comb begin
    w_pick = 4'b0000;
    w_lane = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      w_lane = r_lfsr[1:0] + 2'(i);
      if (!lane_full[w_lane]) w_pick = 4'b0001 << w_lane;
    end
  end

  assign w_ramp            = (r_ramp_cnt == (RAMP_PERIOD - 8'd1));
  assign w_interval_ramped = ({1'b0, interval} < ({1'b0, MIN_INTERVAL} + {1'b0, INTERVAL_STEP}))
                             ? MIN_INTERVAL : (interval - INTERVAL_STEP);

  always_ff @(posedge timerClk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      spawn       <= 4'b0000;
      interval    <= INIT_INTERVAL;
      level       <= 4'd0;
      r_countdown <= INIT_INTERVAL - 8'd1;
      r_ramp_cnt  <= 8'd0;
      r_lfsr      <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
      spawn  <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          interval    <= INIT_INTERVAL;
          level       <= 4'd0;
          r_countdown <= INIT_INTERVAL - 8'd1;
          r_ramp_cnt  <= 8'd0;
          if (play_flag) r_state <= S_RUN;
        end
        S_RUN: begin
          if (game_over) begin
            r_state <= S_DONE;
          end else if (!play_flag) begin
            r_state     <= S_IDLE;
            interval    <= INIT_INTERVAL;
            level       <= 4'd0;
            r_countdown <= INIT_INTERVAL - 8'd1;
            r_ramp_cnt  <= 8'd0;
          end else begin
            if (r_countdown != 8'd0) begin
              r_countdown <= r_countdown - 8'd1;
            end else begin
              spawn       <= w_pick;
              r_countdown <= interval - 8'd1;
            end
            if (w_ramp) begin
              r_ramp_cnt <= 8'd0;
              interval   <= w_interval_ramped;
              if (level != 4'hF) level <= level + 4'd1;
            end else begin
              r_ramp_cnt <= r_ramp_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          if (!play_flag) begin
            r_state     <= S_IDLE;
            interval    <= INIT_INTERVAL;
            level       <= 4'd0;
            r_countdown <= INIT_INTERVAL - 8'd1;
            r_ramp_cnt  <= 8'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q_Idle = r_state[0];
  assign q_Run  = r_state[1];
  assign q_Done = r_state[2];

endmodule
`default_nettype wire
